// File: rtl/codedlock_pkg.sv
// Shared definitions for the coded-lock controller.
// Holds the digit/code geometry, the reset code and the controller state encoding.
// No ports; imported by codedlock_digit_buf and codedlock_ctrl.
package codedlock_pkg;

    localparam int unsigned DIGIT_W  = 4;                    // one key digit {q,u,n,b}
    localparam int unsigned CODE_LEN = 4;                    // digits per code
    localparam int unsigned CODE_W   = DIGIT_W * CODE_LEN;   // packed code vector width
    localparam int unsigned CNT_W    = $clog2(CODE_LEN + 1); // holds 0..CODE_LEN

    // First-entered digit sits in the MSBs.
    localparam logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234;

    typedef enum logic [2:0] {
        StIdle,
        StEntry,
        StCheck,
        StOpen,
        StFail,
        StLockout
    } state_e;

endpackage

// File: rtl/codedlock_digit_buf.sv
// Digit collection buffer: a left-shifting digit register with a digit count and an
// overflow flag. Digits arriving once the buffer already holds CODE_LEN digits are
// dropped and flag overflow instead.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   clr_i    empty the buffer (wins over load_i)
//   load_i   shift digit_i in
//   digit_i  digit value
//   data_o   collected digits, newest in the LSBs
//   count_o  number of digits held
//   full_o   count_o == CODE_LEN
//   ovf_o    a digit was dropped because the buffer was full
module codedlock_digit_buf
    import codedlock_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [CODE_W-1:0]  data_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               ovf_o
);

    logic [CODE_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full;

    assign full = (count_q == CNT_W'(CODE_LEN));

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            data_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load_i) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                data_d  = {data_q[CODE_W-DIGIT_W-1:0], digit_i};
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o  = data_q;
    assign count_o = count_q;
    assign full_o  = full;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/codedlock_ctrl.sv
// Coded-lock sequencer: collects keypad digits, checks them against the stored code,
// drives the unlock (led1) and error/alarm (led2) indicators, counts consecutive
// failures and enforces a lockout window.
// Optional feature macro: CODEDLOCK_REPROG_EN -- adds the prog strobe and a writable
// code register so the code can be changed while unlocked.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   key_val  digit value, sampled with key_vld
//   key_vld  single-cycle digit strobe
//   enter    single-cycle submit strobe
//   clr      single-cycle clear/relock strobe
//   prog     single-cycle reprogram strobe (CODEDLOCK_REPROG_EN only)
//   led1     unlocked indicator
//   led2     error/alarm indicator
//   busy     high in CHECK, FAIL and LOCKOUT
//   tries    consecutive-failure count
module codedlock_ctrl
    import codedlock_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned UNLOCK_CYC  = 500,
    parameter int unsigned ERR_CYC     = 50,
    parameter int unsigned LOCKOUT_CYC = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] key_val,
    input  logic               key_vld,
    input  logic               enter,
    input  logic               clr,
`ifdef CODEDLOCK_REPROG_EN
    input  logic               prog,
`endif
    output logic               led1,
    output logic               led2,
    output logic               busy,
    output logic [1:0]         tries
);

    localparam int unsigned MAX_UE  = (UNLOCK_CYC > ERR_CYC) ? UNLOCK_CYC : ERR_CYC;
    localparam int unsigned MAX_CYC = (MAX_UE > LOCKOUT_CYC) ? MAX_UE : LOCKOUT_CYC;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           tries_q, tries_d;
    logic                 led1_q, led1_d;
    logic                 led2_q, led2_d;
    logic                 busy_q, busy_d;

    logic                 buf_clr, buf_load;
    logic [CODE_W-1:0]    buf_data;
    logic [CNT_W-1:0]     buf_count;
    logic                 buf_full, buf_ovf;
    logic [CODE_W-1:0]    code;
    logic                 match;
    logic [2:0]           tries_inc;
    logic                 lock_hit;
    logic                 timer_zero;

    codedlock_digit_buf u_digit_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (buf_clr),
        .load_i  (buf_load),
        .digit_i (key_val),
        .data_o  (buf_data),
        .count_o (buf_count),
        .full_o  (buf_full),
        .ovf_o   (buf_ovf)
    );

`ifdef CODEDLOCK_REPROG_EN
    logic [CODE_W-1:0] code_q, code_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q <= DEFAULT_CODE;
        end else begin
            code_q <= code_d;
        end
    end

    assign code = code_q;
`else
    assign code = DEFAULT_CODE;
`endif

    // buf_full already implies the digit count equals CODE_LEN.
    assign match      = buf_full && !buf_ovf && (buf_data == code);
    assign tries_inc  = {1'b0, tries_q} + 3'd1;
    assign lock_hit   = (32'(tries_inc) >= MAX_TRIES);
    assign timer_zero = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tries_d  = tries_q;
        buf_clr  = 1'b0;
        buf_load = 1'b0;
`ifdef CODEDLOCK_REPROG_EN
        code_d   = code_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    buf_clr = 1'b1;
                end else if (enter) begin
                    state_d = StCheck;
                end else if (key_vld) begin
                    buf_load = 1'b1;
                    state_d  = StEntry;
                end
            end

            StEntry: begin
                if (clr) begin
                    buf_clr = 1'b1;
                    state_d = StIdle;
                end else if (enter) begin
                    state_d = StCheck;
                end else if (key_vld) begin
                    buf_load = 1'b1;
                end
            end

            StCheck: begin
                buf_clr = 1'b1;
                if (match) begin
                    state_d = StOpen;
                    timer_d = TIMER_W'(UNLOCK_CYC - 1);
                    tries_d = 2'd0;
                end else if (lock_hit) begin
                    state_d = StLockout;
                    timer_d = TIMER_W'(LOCKOUT_CYC - 1);
                    tries_d = 2'(MAX_TRIES);
                end else begin
                    state_d = StFail;
                    timer_d = TIMER_W'(ERR_CYC - 1);
                    tries_d = tries_inc[1:0];
                end
            end

            StOpen: begin
                if (clr) begin
                    buf_clr = 1'b1;
                    state_d = StIdle;
                end
`ifdef CODEDLOCK_REPROG_EN
                else if (prog && buf_full && !buf_ovf) begin
                    code_d  = buf_data;
                    buf_clr = 1'b1;
                    timer_d = TIMER_W'(UNLOCK_CYC - 1);
                end else begin
                    if (prog) begin
                        buf_clr = 1'b1;
                    end else if (key_vld) begin
                        buf_load = 1'b1;
                    end
                    if (timer_zero) begin
                        buf_clr = 1'b1;
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
`else
                else if (timer_zero) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
`endif
            end

            StFail: begin
                if (timer_zero) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            StLockout: begin
                if (timer_zero) begin
                    state_d = StIdle;
                    tries_d = 2'd0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
                buf_clr = 1'b1;
            end
        endcase

        // Indicators follow the next state so they are registered with it.
        led1_d = (state_d == StOpen);
        led2_d = (state_d == StFail) || (state_d == StLockout);
        busy_d = (state_d == StCheck) || (state_d == StFail) || (state_d == StLockout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            tries_q <= 2'd0;
            led1_q  <= 1'b0;
            led2_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
            led1_q  <= led1_d;
            led2_q  <= led2_d;
            busy_q  <= busy_d;
        end
    end

    assign led1  = led1_q;
    assign led2  = led2_q;
    assign busy  = busy_q;
    assign tries = tries_q;

endmodule

// File: tb/tb_codedlock_ctrl.sv
// Directed self-checking bench for codedlock_ctrl (default parameters).
module tb_codedlock_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_val;
    logic       key_vld;
    logic       enter;
    logic       clr;
`ifdef CODEDLOCK_REPROG_EN
    logic       prog;
`endif
    logic       led1;
    logic       led2;
    logic       busy;
    logic [1:0] tries;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    codedlock_ctrl u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_val (key_val),
        .key_vld (key_vld),
        .enter   (enter),
        .clr     (clr),
`ifdef CODEDLOCK_REPROG_EN
        .prog    (prog),
`endif
        .led1    (led1),
        .led2    (led2),
        .busy    (busy),
        .tries   (tries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_val = d;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
    endtask

    task automatic code4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
        end
    endtask

    // After this the DUT is in CHECK.
    task automatic submit();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Count consecutive sampled cycles the selected LED stays high (bounded).
    task automatic hold_len(input bit sel_led2, output int cnt);
        cnt = 0;
        while ((((sel_led2 ? led2 : led1) === 1'b1)) && (cnt < 3000)) begin
            cnt++;
            tick();
        end
    endtask

    task automatic unlock_then_clr(input string tag);
        code4(16'h1234);
        submit();
        tick();
        check({tag, "_led1"}, led1, 1);
        check({tag, "_tries"}, tries, 0);
        pulse_clr();
    endtask

    task automatic fail_once(input string tag, input logic [1:0] exp_tries);
        code4(16'h1235);
        submit();
        tick();
        check({tag, "_led2"}, led2, 1);
        check({tag, "_tries"}, tries, exp_tries);
    endtask

    initial begin
        rst_n   = 1'b0;
        key_val = '0;
        key_vld = 1'b0;
        enter   = 1'b0;
        clr     = 1'b0;
`ifdef CODEDLOCK_REPROG_EN
        prog    = 1'b0;
`endif
        tick();
        tick();
        check("rst_led1", led1, 0);
        check("rst_led2", led2, 0);
        check("rst_busy", busy, 0);
        check("rst_tries", tries, 0);
        rst_n = 1'b1;
        tick();

        // Correct code: CHECK one cycle, then OPEN for 500 cycles.
        code4(16'h1234);
        submit();
        check("chk_busy", busy, 1);
        check("chk_led1", led1, 0);
        tick();
        check("open_led1", led1, 1);
        check("open_busy", busy, 0);
        hold_len(1'b0, n);
        check("open_len", n, 500);
        check("open_tries", tries, 0);

        // Two plain failures, then lockout on the third.
        fail_once("fail1", 2'd1);
        hold_len(1'b1, n);
        check("fail1_len", n, 50);
        fail_once("fail2", 2'd2);
        hold_len(1'b1, n);
        check("fail2_len", n, 50);
        fail_once("lock", 2'd3);
        check("lock_busy", busy, 1);
        // Keys and enter during lockout are ignored; 5 of the 2000 cycles pass here.
        code4(16'h1234);
        submit();
        check("lock_ign_led1", led1, 0);
        hold_len(1'b1, n);
        check("lock_len", n, 1995);
        check("lock_end_tries", tries, 0);
        check("lock_end_busy", busy, 0);
        unlock_then_clr("post_lock");
        check("post_lock_clr", led1, 0);

        // Overflow, short entry and empty submit all fail.
        code4(16'h1234);
        press(4'h4);
        submit();
        tick();
        check("ovf_led2", led2, 1);
        check("ovf_tries", tries, 1);
        hold_len(1'b1, n);
        unlock_then_clr("rec1");
        press(4'h1);
        press(4'h2);
        submit();
        tick();
        check("short_led2", led2, 1);
        hold_len(1'b1, n);
        unlock_then_clr("rec2");
        submit();
        tick();
        check("empty_led2", led2, 1);
        check("empty_tries", tries, 1);
        hold_len(1'b1, n);

        // clr during entry keeps tries, restarts the entry.
        press(4'h1);
        press(4'h2);
        pulse_clr();
        check("clr_tries", tries, 1);
        code4(16'h1234);
        submit();
        tick();
        check("clr_unlock", led1, 1);
        repeat (99) tick();
        check("open_c99", led1, 1);
        pulse_clr();
        check("clr_open", led1, 0);

        // Digit coincident with enter is dropped.
        code4(16'h1234);
        key_val = 4'h9;
        key_vld = 1'b1;
        enter   = 1'b1;
        tick();
        key_vld = 1'b0;
        enter   = 1'b0;
        tick();
        check("coinc_unlock", led1, 1);
        pulse_clr();

        // Reset mid-lockout.
        fail_once("rl1", 2'd1);
        hold_len(1'b1, n);
        fail_once("rl2", 2'd2);
        hold_len(1'b1, n);
        fail_once("rl3", 2'd3);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rl_led1", led1, 0);
        check("rl_led2", led2, 0);
        check("rl_busy", busy, 0);
        check("rl_tries", tries, 0);
        tick();

`ifdef CODEDLOCK_REPROG_EN
        code4(16'h1234);
        submit();
        tick();
        check("rp_open", led1, 1);
        code4(16'h5678);
        prog = 1'b1;
        tick();
        prog = 1'b0;
        check("rp_still_open", led1, 1);
        pulse_clr();
        code4(16'h1234);
        submit();
        tick();
        check("rp_old_fails", led2, 1);
        hold_len(1'b1, n);
        code4(16'h5678);
        submit();
        tick();
        check("rp_new_opens", led1, 1);
        pulse_clr();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
